// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter (rev 1.0): shares one single-port SRAM between fetch (I, read-only) and memory stage (D, read/write).
// Optional macro ARB_STARVE_GUARD_EN bounds fetch starvation to STARVE_MAX consecutive D grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  flush,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  if (RD_LAT < 1 || RD_LAT > 4 || STARVE_MAX < 1) begin : g_bad_param
    $error("mem_port_arbiter: RD_LAT must be 1..4 and STARVE_MAX >= 1");
  end

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [2:0] c_RD_LAT = 3'(RD_LAT);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       r_owner_d, w_owner_d_nxt;
  logic       r_we, w_we_nxt;
  logic       r_drop, w_drop_nxt;

  logic w_resp;
  logic w_window;
  logic w_force_i;
  logic w_i_gnt;
  logic w_d_gnt;

  assign w_resp   = (r_state == S_BUSY) && (r_cnt == 3'd1);
  // Gating with rst_ keeps every output at 0 while reset is held, independent of the request inputs.
  assign w_window = rst_ && ((r_state == S_IDLE) || w_resp);

`ifdef ARB_STARVE_GUARD_EN
  localparam int              c_SW   = $clog2(STARVE_MAX + 1);
  localparam logic [c_SW-1:0] c_SMAX = c_SW'(STARVE_MAX);

  logic [c_SW-1:0] r_starve;

  assign w_force_i = (r_starve >= c_SMAX) && i_req && !flush;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_starve <= '0;
    end else if (w_i_gnt || !i_req) begin
      r_starve <= '0;
    end else if (w_d_gnt && (r_starve < c_SMAX)) begin
      r_starve <= r_starve + 1'b1;
    end
  end
`else
  assign w_force_i = 1'b0;
`endif

  assign w_d_gnt = w_window && d_req && !w_force_i;
  assign w_i_gnt = w_window && i_req && !flush && (!d_req || w_force_i);

  assign i_gnt = w_i_gnt;
  assign d_gnt = w_d_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (w_i_gnt) begin
      mem_en   = 1'b1;
      mem_addr = i_addr;
    end
  end

  // A flush in the response cycle itself must also hide the fetch data.
  assign i_rvalid = w_resp && !r_owner_d && !r_drop && !flush;
  assign d_rvalid = w_resp && r_owner_d;
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = (d_rvalid && !r_we) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_owner_d <= 1'b0;
      r_we      <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_owner_d <= w_owner_d_nxt;
      r_we      <= w_we_nxt;
      r_drop    <= w_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_owner_d_nxt = r_owner_d;
    w_we_nxt      = r_we;
    w_drop_nxt    = r_drop;
    if (w_i_gnt || w_d_gnt) begin
      w_state_nxt   = S_BUSY;
      w_cnt_nxt     = c_RD_LAT;
      w_owner_d_nxt = w_d_gnt;
      w_we_nxt      = w_d_gnt && d_we;
      w_drop_nxt    = 1'b0;
    end else if (r_state == S_BUSY) begin
      if (r_cnt == 3'd1) begin
        w_state_nxt   = S_IDLE;
        w_cnt_nxt     = 3'd0;
        w_owner_d_nxt = 1'b0;
        w_we_nxt      = 1'b0;
        w_drop_nxt    = 1'b0;
      end else begin
        w_cnt_nxt = r_cnt - 3'd1;
        if (flush && !r_owner_d) begin
          w_drop_nxt = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
